// File: rtl/return_address_stack_ckpt.sv
// Circular return-address stack with tagged checkpoint slots, one per in-flight branch.
// A restore rewinds sp/count and repairs the top entry in case wrong-path code overwrote it.
module return_address_stack_ckpt #(
  parameter int XLEN            = 32,
  parameter int STACK_SIZE      = 16,
  parameter int NUM_CHECKPOINTS = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [XLEN-1:0]                    address_in,
  input  logic                               push,
  input  logic                               pop,
  input  logic                               checkpoint,
  input  logic [$clog2(NUM_CHECKPOINTS)-1:0] checkpoint_tag,
  input  logic                               restore,
  input  logic [$clog2(NUM_CHECKPOINTS)-1:0] restore_tag,
  output logic [XLEN-1:0]                    address_out,
  output logic                               valid_out,
  output logic                               overflow,
  output logic                               underflow,
  output logic [$clog2(STACK_SIZE):0]        count,
  output logic [$clog2(STACK_SIZE)-1:0]      stack_pointer
);

  localparam int SPW = $clog2(STACK_SIZE);
  localparam int CW  = SPW + 1;

  logic [XLEN-1:0] stack_q [STACK_SIZE];
  logic [XLEN-1:0] stack_d [STACK_SIZE];
  logic [SPW-1:0]  sp_q, sp_d;
  logic [CW-1:0]   count_q, count_d;

  logic [SPW-1:0]  slot_sp_q    [NUM_CHECKPOINTS];
  logic [SPW-1:0]  slot_sp_d    [NUM_CHECKPOINTS];
  logic [CW-1:0]   slot_count_q [NUM_CHECKPOINTS];
  logic [CW-1:0]   slot_count_d [NUM_CHECKPOINTS];
  logic [XLEN-1:0] slot_top_q   [NUM_CHECKPOINTS];
  logic [XLEN-1:0] slot_top_d   [NUM_CHECKPOINTS];

  logic [XLEN-1:0] address_out_q, address_out_d;
  logic            valid_out_q, valid_out_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  logic [SPW-1:0]  top_idx;
  logic [SPW-1:0]  restore_top_idx;
  logic [SPW-1:0]  ckpt_top_idx;
  logic            pop_ok;

  always_comb begin
    stack_d         = stack_q;
    sp_d            = sp_q;
    count_d         = count_q;
    slot_sp_d       = slot_sp_q;
    slot_count_d    = slot_count_q;
    slot_top_d      = slot_top_q;
    address_out_d   = '0;
    valid_out_d     = 1'b0;
    overflow_d      = 1'b0;
    underflow_d     = 1'b0;
    top_idx         = sp_q - SPW'(1);
    restore_top_idx = slot_sp_q[restore_tag] - SPW'(1);
    ckpt_top_idx    = '0;
    pop_ok          = pop && (count_q != '0);

    if (restore) begin
      sp_d    = slot_sp_q[restore_tag];
      count_d = slot_count_q[restore_tag];
      if (slot_count_q[restore_tag] != '0)
        stack_d[restore_top_idx] = slot_top_q[restore_tag];
    end else begin
      if (pop && !pop_ok)
        underflow_d = 1'b1;
      if (pop_ok) begin
        address_out_d = stack_q[top_idx];
        valid_out_d   = 1'b1;
      end

      // pop+push on a non-empty stack replaces the top in place
      if (pop_ok && push) begin
        stack_d[top_idx] = address_in;
      end else if (pop_ok) begin
        sp_d    = sp_q - SPW'(1);
        count_d = count_q - CW'(1);
      end else if (push) begin
        stack_d[sp_q] = address_in;
        sp_d          = sp_q + SPW'(1);
        if (count_q == CW'(STACK_SIZE))
          overflow_d = 1'b1;
        else
          count_d = count_q + CW'(1);
      end

      ckpt_top_idx = sp_d - SPW'(1);
      if (checkpoint) begin
        slot_sp_d[checkpoint_tag]    = sp_d;
        slot_count_d[checkpoint_tag] = count_d;
        slot_top_d[checkpoint_tag]   = (count_d == '0) ? '0 : stack_d[ckpt_top_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STACK_SIZE; i++)
        stack_q[i] <= '0;
      for (int j = 0; j < NUM_CHECKPOINTS; j++) begin
        slot_sp_q[j]    <= '0;
        slot_count_q[j] <= '0;
        slot_top_q[j]   <= '0;
      end
      sp_q          <= '0;
      count_q       <= '0;
      address_out_q <= '0;
      valid_out_q   <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      stack_q       <= stack_d;
      slot_sp_q     <= slot_sp_d;
      slot_count_q  <= slot_count_d;
      slot_top_q    <= slot_top_d;
      sp_q          <= sp_d;
      count_q       <= count_d;
      address_out_q <= address_out_d;
      valid_out_q   <= valid_out_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end

  assign address_out   = address_out_q;
  assign valid_out     = valid_out_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;
  assign count         = count_q;
  assign stack_pointer = sp_q;

endmodule
